// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader.
// Contents: default clock/baud values, the frame sync byte, and the state
// enums for the frame FSM and the UART receiver.
package prog_loader_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF   = 115_200;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StAddr,
    StData,
    StCsum,
    StDone
  } frame_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   rx         - serial input, idle high, LSB first
//   byte_data  - received byte, valid while byte_valid is high
//   byte_valid - one-cycle strobe for a byte with a good stop bit
//   frame_err  - one-cycle strobe for a byte whose stop bit read 0
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned HALF = (DIV / 2) - 1;

  logic      sync1_q, rx_s_q, rx_prev_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  // Synchronizer resets to the idle level so no false start follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == CW'(HALF)) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A glitch that is high again at mid-bit re-arms the receiver.
          state_d = rx_s_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = rx_s_q;
          ferr_d  = !rx_s_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives framed bytes over UART and writes them to ROM.
// Frame: 0xA5, LEN, ADDR, LEN data bytes, CSUM = (LEN + ADDR + data) mod 256.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   rx   - UART serial input
//   edit - programming-mode request, high for the duration of a frame
//   unit - ROM write address
//   code - ROM write data
//   send - one-cycle ROM write strobe
//   done - one-cycle pulse after a frame with a good checksum
//   err  - sticky fault flag, cleared by the next accepted sync byte
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned BAUD        = BAUD_DEF,
  parameter int unsigned TIMEOUT_CYC = 16 * (CLK_HZ / BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       edit,
  output logic [7:0] unit,
  output logic [7:0] code,
  output logic       send,
  output logic       done,
  output logic       err
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  uart_rx #(
    .DIV(DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  frame_state_e state_q, state_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         edit_q, edit_d;
  logic         send_q, send_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [7:0]   unit_q, unit_d;
  logic [7:0]   code_q, code_d;
  logic         in_frame;
  logic         abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      edit_q  <= 1'b0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unit_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      edit_q  <= edit_d;
      send_q  <= send_d;
      done_q  <= done_d;
      err_q   <= err_d;
      unit_q  <= unit_d;
      code_q  <= code_d;
    end
  end

  // Frame is open while waiting for LEN..CSUM; DONE is a one-cycle tail.
  assign in_frame = (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    edit_d  = edit_q;
    send_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    unit_d  = unit_q;
    code_d  = code_q;
    abort   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          state_d = StLen;
          edit_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      StLen: begin
        if (byte_valid) begin
          if (rx_byte == 8'd0) begin
            abort = 1'b1;
          end else begin
            len_d   = rx_byte;
            sum_d   = rx_byte;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (byte_valid) begin
          addr_d  = rx_byte;
          sum_d   = sum_q + rx_byte;
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (byte_valid) begin
          send_d = 1'b1;
          unit_d = addr_q;
          code_d = rx_byte;
          addr_d = addr_q + 8'd1;
          sum_d  = sum_q + rx_byte;
          cnt_d  = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (byte_valid) begin
          if (rx_byte == sum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            abort = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        edit_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Inter-byte gap watchdog, restarted by every received byte.
    if (in_frame) begin
      if (byte_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        abort = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (frame_err) begin
      err_d = 1'b1;
      if (in_frame) abort = 1'b1;
    end

    if (abort) begin
      state_d = StIdle;
      edit_d  = 1'b0;
      err_d   = 1'b1;
      send_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign edit = edit_q;
  assign unit = unit_q;
  assign code = code_q;
  assign send = send_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames,
// checked against a frame-level reference model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned TMO    = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       edit, send, done, err;
  logic [7:0] unit, code;

  prog_loader #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .edit(edit),
    .unit(unit),
    .code(code),
    .send(send),
    .done(done),
    .err (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending writes {unit, code}, expected done count and err.
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_unit = 8'h00;
  logic [7:0]  exp_code = 8'h00;
  int          exp_done = 0;
  int          act_done = 0;
  bit          exp_err  = 1'b0;
  logic [7:0]  fb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: parse a byte list; 'aborted' means a timeout or
  // framing fault follows the last byte.
  task automatic model(input logic [7:0] b[$], input bit aborted);
    int k = 0;
    logic [7:0] len, addr, sum;
    while (k < b.size() && b[k] != SYNC_BYTE) k++;
    if (k >= b.size()) return;
    k++;
    exp_err = 1'b0;
    if (k >= b.size()) begin if (aborted) exp_err = 1'b1; return; end
    len = b[k]; k++;
    if (len == 8'd0) begin exp_err = 1'b1; return; end
    if (k >= b.size()) begin if (aborted) exp_err = 1'b1; return; end
    addr = b[k]; k++;
    sum = len + addr;
    for (int i = 0; i < int'(len); i++) begin
      if (k >= b.size()) begin if (aborted) exp_err = 1'b1; return; end
      exp_wr.push_back({8'(int'(addr) + i), b[k]});
      sum = sum + b[k];
      k++;
    end
    if (k >= b.size()) begin if (aborted) exp_err = 1'b1; return; end
    if (b[k] == sum) exp_done++;
    else exp_err = 1'b1;
  endtask

  // Per-cycle output checker.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_outputs", {edit, send, done, err, unit, code}, 64'd0);
      exp_unit = 8'h00;
      exp_code = 8'h00;
    end else begin
      if (send) begin
        check("send_needs_edit", edit, 1);
        if (exp_wr.size() == 0) begin
          check("spurious_send", send, 0);
        end else begin
          logic [15:0] w;
          w = exp_wr.pop_front();
          check("write_unit_code", {unit, code}, w);
          exp_unit = w[15:8];
          exp_code = w[7:0];
        end
      end else begin
        check("hold_unit_code", {unit, code}, {exp_unit, exp_code});
      end
      if (done) begin
        act_done++;
        check("done_needs_edit", edit, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] v, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int gap_max);
    bit seen = 1'b0;
    foreach (b[j]) begin
      send_byte(b[j], 1'b1);
      if (!seen && b[j] == SYNC_BYTE) begin
        seen = 1'b1;
        repeat (3) @(negedge clk);
        check("edit_after_sync", edit, 1);
        check("err_clear_on_sync", err, 0);
      end
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic finish_frame(input string name, input int wait_cyc);
    repeat (wait_cyc) @(negedge clk);
    check({name, "_edit"}, edit, 0);
    check({name, "_err"}, err, 64'(exp_err));
    check({name, "_done_cnt"}, act_done, exp_done);
    check({name, "_pending_writes"}, exp_wr.size(), 0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: cycle budget expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_state", {edit, send, done, err, unit, code}, 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic three-byte frame.
    fb = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h79};
    model(fb, 1'b0);
    check("model_writes_a", {exp_wr[0], exp_wr[1], exp_wr[2]}, 64'h1011_1122_1233);
    send_frame(fb, 20);
    finish_frame("frame_a", 20);
    check("lit_a_done", act_done, 1);
    check("lit_a_err", err, 0);

    // Address wrap FF -> 00.
    fb = '{8'hA5, 8'h02, 8'hFF, 8'hAA, 8'hBB, 8'h66};
    model(fb, 1'b0);
    send_frame(fb, 20);
    finish_frame("frame_wrap", 20);
    check("lit_wrap_done", act_done, 2);
    check("lit_wrap_unit", unit, 8'h00);

    // Bad checksum: write stands, no done.
    fb = '{8'hA5, 8'h01, 8'h20, 8'h55, 8'h00};
    model(fb, 1'b0);
    send_frame(fb, 20);
    finish_frame("frame_badsum", 20);
    check("lit_badsum_err", err, 1);
    check("lit_badsum_done", act_done, 2);

    // Junk byte ignored, LEN=0 faults.
    fb = '{8'h5A, 8'hA5, 8'h00};
    model(fb, 1'b0);
    send_frame(fb, 20);
    finish_frame("frame_len0", 20);
    check("lit_len0_err", err, 1);

    // Next sync clears err (checked inside send_frame).
    fb = '{8'hA5, 8'h01, 8'h07, 8'h09, 8'h11};
    model(fb, 1'b0);
    send_frame(fb, 20);
    finish_frame("frame_recover", 20);
    check("lit_recover_err", err, 0);

    // Timeout mid-frame.
    fb = '{8'hA5, 8'h02, 8'h40, 8'h01};
    model(fb, 1'b1);
    send_frame(fb, 0);
    check("timeout_edit_before", edit, 1);
    finish_frame("frame_timeout", TMO + 30);
    check("lit_timeout_err", err, 1);

    // Framing error mid-frame.
    fb = '{8'hA5, 8'h03, 8'h50, 8'h0C};
    model(fb, 1'b1);
    send_frame(fb, 10);
    send_byte(8'h0D, 1'b0);
    finish_frame("frame_stop0", 10);
    check("lit_stop0_err", err, 1);

    // Reset between first and second data byte.
    fb = '{8'hA5, 8'h03, 8'h30, 8'h01};
    model(fb, 1'b0);
    send_frame(fb, 5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {edit, send, done, err, unit, code}, 64'd0);
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fb = '{8'h02, 8'h03, 8'h36};
    model(fb, 1'b0);
    send_frame(fb, 10);
    finish_frame("after_reset_tail", 20);
    fb = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h08};
    model(fb, 1'b0);
    send_frame(fb, 10);
    finish_frame("after_reset_frame", 20);
    check("lit_reset_unit", unit, 8'h02);

    // Random frames.
    for (int f = 0; f < 20; f++) begin
      logic [7:0] len, addr, s, v;
      fb = {};
      repeat ($urandom_range(0, 2)) begin
        v = 8'($urandom_range(0, 255));
        if (v == SYNC_BYTE) v = 8'h00;
        fb.push_back(v);
      end
      len  = 8'($urandom_range(1, 6));
      addr = (f % 5 == 0) ? 8'hFD : 8'($urandom_range(0, 255));
      s    = len + addr;
      fb.push_back(SYNC_BYTE);
      fb.push_back(len);
      fb.push_back(addr);
      for (int i = 0; i < int'(len); i++) begin
        v = 8'($urandom_range(0, 255));
        fb.push_back(v);
        s = s + v;
      end
      if ($urandom_range(0, 4) == 0) s = s ^ 8'h3C;
      fb.push_back(s);
      model(fb, 1'b0);
      send_frame(fb, 30);
      finish_frame("rand_frame", 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
